turret_aim_ctrl: RTL and testbench
==================================

# turret_aim_ctrl

- Consumes the 9-bit zone-hit vector from the detection buffer stage: one bit per cell of a 3×3 grid, index = row*3+col, row 0 top, col 0 left.
- Selects one target cell and slews pan and tilt hobby servos toward it using two PWM outputs.
- After the servos settle, issues a timed fire pulse, gated by `arm`.
- Sits between the detection buffer and the turret actuators.

## Interface
Parameters:
- `PWM_PERIOD`, 2_000_000: clock cycles per servo frame (20 ms at 100 MHz).
- `PULSE_MIN`, 100_000: pulse width for col/row 0, in cycles.
- `PULSE_STEP`, 50_000: width increment per col/row index.
- `SLEW_STEP`, 5_000: maximum width change per frame.
- `SETTLE_PERIODS`, 10: frames to wait after the target width is reached.
- `FIRE_CYCLES`, 5_000_000: width of the fire pulse, in cycles.
- `HOME_PERIODS`, 250: idle frames before homing (only with `AIM_AUTO_HOME_EN`).

Ports:
- `fclk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `zone_valid` in 1: one-cycle strobe; `zone` is valid in the same cycle.
- `zone` in 9: zone-hit vector.
- `arm` in 1: fire enable, level.
- `pan_pwm` out 1: pan servo PWM.
- `tilt_pwm` out 1: tilt servo PWM.
- `fire` out 1: trigger drive.
- `target_valid` out 1: a target is latched.
- `target_idx` out 4: latched cell, 0–8.
- `busy` out 1: high in AIM, SETTLE and FIRE.

## Operation
Target selection:
- Priority order is 4, 1, 3, 5, 7, 0, 2, 6, 8 (centre first, then edges, then corners).
- The first set bit in this order wins.

Servo targets:
- Pan target width = PULSE_MIN + col*PULSE_STEP.
- Tilt target width = PULSE_MIN + row*PULSE_STEP.
- Current width moves toward its target by min(SLEW_STEP, |difference|) on each `frame_tick`.

PWM:
- A shared frame counter runs 0..PWM_PERIOD-1.
- `frame_tick` is high for the cycle where the counter equals PWM_PERIOD-1.
- Each PWM output is high while counter < current width for that axis.

FSM states:
- IDLE: no target.
  - `zone_valid` with nonzero `zone`: latch target, go to AIM.
  - `zone_valid` with zero `zone`: stay in IDLE.
- AIM: on the `frame_tick` where both current widths equal their targets, go to SETTLE and clear the settle count.
- SETTLE: counts `frame_tick`s. At SETTLE_PERIODS:
  - `arm`=1: go to FIRE.
  - `arm`=0: go to IDLE with the target kept (`target_valid` stays 1, servos hold).
- FIRE: `fire`=1 for exactly FIRE_CYCLES cycles, then go to IDLE with `target_valid` cleared.

Retargeting and input handling:
- `zone_valid` with nonzero `zone` in AIM or SETTLE: re-latch the target, go to AIM, restart slew from the current widths.
- `zone_valid` with zero `zone` in AIM or SETTLE: clear `target_valid`, go to IDLE, servos hold their current widths.
- `zone_valid` during FIRE: ignored; the fire pulse always completes.
- Dropping `arm` during FIRE: no effect on the pulse.

Reset values:
- Both current and target widths = PULSE_MIN+PULSE_STEP (centre).
- Frame counter = 0, state = IDLE.
- `fire`, `target_valid`, `busy` = 0; `target_idx` = 4.
- `pan_pwm` and `tilt_pwm` = 0.

Arithmetic and parameter rules:
- Width and counter registers are $clog2(PWM_PERIOD) bits wide.
- Slew arithmetic is unsigned compare-then-add or compare-then-subtract; it never overshoots or underflows.
- Required: PULSE_MIN + 2*PULSE_STEP < PWM_PERIOD (checked by an elaboration-time assertion).

## Timing
- `zone_valid` in cycle N: `target_idx`, `target_valid`, `busy` and the state update at cycle N+1.
- The new target width takes effect at the next `frame_tick`. A changed width applies from the next frame start, so no glitched partial frame is produced.
- AIM to SETTLE: on the `frame_tick` at which the widths match.
- SETTLE to FIRE: on the SETTLE_PERIODS-th `frame_tick`. `fire` rises the following cycle.
- `fire` falls FIRE_CYCLES cycles after it rises; the state returns to IDLE in that same cycle.
- Asserting `reset` at any time, including mid-FIRE: `fire` drops asynchronously and all registers take their reset values immediately.

## Configuration
- `AIM_AUTO_HOME_EN` defined:
  - IDLE with `target_valid`=0 counts `frame_tick`s.
  - At HOME_PERIODS, both target widths are set to centre and the servos slew home, while the state stays IDLE.
  - Any `zone_valid` clears the count.
- `AIM_AUTO_HOME_EN` undefined: the servos hold their last position indefinitely and the home counter is absent.

## Structure
- Package `turret_pkg` holds:
  - the `aim_state_t` enum (IDLE, AIM, SETTLE, FIRE);
  - the 9-entry zone priority constant array;
  - row/col lookup functions;
  - the `ZONES`=9 constant.
- Sub-module `servo_slew_pwm` is instantiated twice, one per axis.
  - Inputs: `fclk`, `reset`, `frame_tick`, frame counter, target width.
  - Outputs: PWM bit and `at_target`.
- The frame counter and FSM live in the top level.

## Test plan
Bench parameters: PWM_PERIOD=100, PULSE_MIN=10, PULSE_STEP=5, SLEW_STEP=1, SETTLE_PERIODS=2, FIRE_CYCLES=4.
- Reset release: `pan_pwm` and `tilt_pwm` are high for 15 of every 100 cycles; `target_idx`=4, `fire`=0.
- `zone`=9'b100000001 (bits 0 and 8), `arm`=1:
  - `target_idx`=0;
  - pan and tilt widths step 15→14→13→12→11→10 over 5 frames;
  - SETTLE lasts 2 frames, then `fire` is high for exactly 4 cycles and `target_valid` goes to 0.
- `zone`=9'b000010010 (bits 1 and 4): `target_idx`=4 (centre wins), no slew, AIM→SETTLE at the first `frame_tick`.
- Retarget mid-slew: cell 8, then cell 6 after 2 frames:
  - pan reverses from width 17 toward 10 without overshoot;
  - tilt continues toward 20.
- `arm`=0 with target 2: `fire` stays 0, return to IDLE with `target_valid`=1; a `zone_valid` during a later FIRE (`arm`=1) leaves the 4-cycle pulse unchanged.
- `reset` asserted in the second FIRE cycle: `fire`=0 in the same cycle and widths return to 15.

Source files
------------

// File: rtl/turret_pkg.sv
// turret_pkg: shared types and constants for the turret aim controller.
//   aim_state_t   - controller states (IDLE, AIM, SETTLE, FIRE)
//   ZONES         - number of grid cells (3x3)
//   ZONE_PRIO     - cell search order: centre, edges, corners
//   zone_row/col  - cell index to grid row/column
package turret_pkg;

  localparam int unsigned ZONES = 9;

  typedef enum logic [1:0] {
    IDLE,
    AIM,
    SETTLE,
    FIRE
  } aim_state_t;

  localparam logic [3:0] ZONE_PRIO [ZONES] = '{
    4'd4, 4'd1, 4'd3, 4'd5, 4'd7, 4'd0, 4'd2, 4'd6, 4'd8
  };

  function automatic logic [1:0] zone_row(input logic [3:0] idx);
    case (idx)
      4'd0, 4'd1, 4'd2: zone_row = 2'd0;
      4'd3, 4'd4, 4'd5: zone_row = 2'd1;
      default:          zone_row = 2'd2;
    endcase
  endfunction

  function automatic logic [1:0] zone_col(input logic [3:0] idx);
    case (idx)
      4'd0, 4'd3, 4'd6: zone_col = 2'd0;
      4'd1, 4'd4, 4'd7: zone_col = 2'd1;
      default:          zone_col = 2'd2;
    endcase
  endfunction

endpackage

// File: rtl/servo_slew_pwm.sv
// servo_slew_pwm: one servo axis. Holds the current pulse width, slews it
// toward target_width by at most SLEW_STEP per frame_tick, and drives a
// registered PWM bit that is high while frame_cnt < current width.
//   fclk, reset   - clock, asynchronous active-high reset
//   frame_tick    - slew update strobe (last cycle of a frame)
//   frame_cnt     - shared frame counter
//   target_width  - width to slew toward
//   pwm           - servo PWM output
//   at_target     - current width equals target_width
module servo_slew_pwm #(
  parameter int unsigned    W          = 8,
  parameter logic [W-1:0]   HOME_WIDTH = '0,
  parameter logic [W-1:0]   SLEW_STEP  = 1
) (
  input  logic         fclk,
  input  logic         reset,
  input  logic         frame_tick,
  input  logic [W-1:0] frame_cnt,
  input  logic [W-1:0] target_width,
  output logic         pwm,
  output logic         at_target
);

  logic [W-1:0] width_q, width_d;
  logic [W-1:0] diff;
  logic         pwm_q, pwm_d;

  // Width only moves on the frame's last cycle, where the PWM is already low,
  // so every frame is produced with a single consistent width.
  always_comb begin
    width_d = width_q;
    diff    = '0;
    if (frame_tick) begin
      if (width_q < target_width) begin
        diff    = target_width - width_q;
        width_d = (diff > SLEW_STEP) ? width_q + SLEW_STEP : target_width;
      end else if (width_q > target_width) begin
        diff    = width_q - target_width;
        width_d = (diff > SLEW_STEP) ? width_q - SLEW_STEP : target_width;
      end
    end
    pwm_d = (frame_cnt < width_q);
  end

  always_ff @(posedge fclk or posedge reset) begin
    if (reset) begin
      width_q <= HOME_WIDTH;
      pwm_q   <= 1'b0;
    end else begin
      width_q <= width_d;
      pwm_q   <= pwm_d;
    end
  end

  assign pwm       = pwm_q;
  assign at_target = (width_q == target_width);

endmodule

// File: rtl/turret_aim_ctrl.sv
// turret_aim_ctrl: picks one cell from a 3x3 zone-hit vector, slews pan/tilt
// servos to it, waits for settling, then issues a timed fire pulse if armed.
//   fclk, reset    - clock, asynchronous active-high reset
//   zone_valid     - one-cycle strobe qualifying zone
//   zone[8:0]      - hit vector, index = row*3+col
//   arm            - fire enable level
//   pan_pwm/tilt_pwm - servo PWM outputs
//   fire           - trigger drive
//   target_valid   - a target is latched
//   target_idx     - latched cell
//   busy           - in AIM, SETTLE or FIRE
// Optional feature macro: AIM_AUTO_HOME_EN (idle homing to centre).
module turret_aim_ctrl
  import turret_pkg::*;
#(
  parameter int unsigned PWM_PERIOD     = 2_000_000,
  parameter int unsigned PULSE_MIN      = 100_000,
  parameter int unsigned PULSE_STEP     = 50_000,
  parameter int unsigned SLEW_STEP      = 5_000,
  parameter int unsigned SETTLE_PERIODS = 10,
  parameter int unsigned FIRE_CYCLES    = 5_000_000,
  parameter int unsigned HOME_PERIODS   = 250
) (
  input  logic             fclk,
  input  logic             reset,
  input  logic             zone_valid,
  input  logic [ZONES-1:0] zone,
  input  logic             arm,
  output logic             pan_pwm,
  output logic             tilt_pwm,
  output logic             fire,
  output logic             target_valid,
  output logic [3:0]       target_idx,
  output logic             busy
);

  localparam int unsigned W  = $clog2(PWM_PERIOD);
  localparam int unsigned SW = $clog2(SETTLE_PERIODS + 1);
  localparam int unsigned FW = $clog2(FIRE_CYCLES + 1);

  localparam logic [W-1:0]  LAST_CNT    = W'(PWM_PERIOD - 1);
  localparam logic [W-1:0]  CENTRE      = W'(PULSE_MIN + PULSE_STEP);
  localparam logic [W-1:0]  SLEW_W      = W'(SLEW_STEP);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_PERIODS - 1);
  localparam logic [FW-1:0] FIRE_LAST   = FW'(FIRE_CYCLES - 1);

  if (PULSE_MIN + 2 * PULSE_STEP >= PWM_PERIOD) begin : g_width_cfg_err
    $error("turret_aim_ctrl: PULSE_MIN + 2*PULSE_STEP must be below PWM_PERIOD");
  end
  if (SETTLE_PERIODS == 0 || FIRE_CYCLES == 0 || HOME_PERIODS == 0) begin : g_count_cfg_err
    $error("turret_aim_ctrl: SETTLE_PERIODS, FIRE_CYCLES and HOME_PERIODS must be nonzero");
  end

  function automatic logic [W-1:0] axis_width(input logic [1:0] pos);
    axis_width = W'(PULSE_MIN + 32'(pos) * PULSE_STEP);
  endfunction

  aim_state_t    state_q, state_d;
  logic [W-1:0]  cnt_q, cnt_d;
  logic [W-1:0]  pan_tgt_q, pan_tgt_d, tilt_tgt_q, tilt_tgt_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [FW-1:0] fire_cnt_q, fire_cnt_d;
  logic [3:0]    idx_q, idx_d;
  logic          tv_q, tv_d;
  logic          fire_q, fire_d;
  logic          slew_en_q, slew_en_d;
  logic          frame_tick, slew_tick;
  logic          pan_at, tilt_at;
  logic [3:0]    sel_idx;
  logic          sel_found;
  logic          do_latch;
`ifdef AIM_AUTO_HOME_EN
  localparam int unsigned HW = $clog2(HOME_PERIODS + 1);
  logic [HW-1:0] home_q, home_d;
`endif

  assign frame_tick = (cnt_q == LAST_CNT);
  // Slewing is frozen after an abort so the servos hold where they stopped.
  assign slew_tick  = frame_tick & slew_en_q;
  assign cnt_d      = frame_tick ? '0 : cnt_q + 1'b1;

  always_comb begin
    sel_idx   = 4'd4;
    sel_found = 1'b0;
    for (int unsigned i = 0; i < ZONES; i++) begin
      if (!sel_found && zone[ZONE_PRIO[i]]) begin
        sel_idx   = ZONE_PRIO[i];
        sel_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    tv_d       = tv_q;
    idx_d      = idx_q;
    pan_tgt_d  = pan_tgt_q;
    tilt_tgt_d = tilt_tgt_q;
    settle_d   = settle_q;
    fire_cnt_d = fire_cnt_q;
    slew_en_d  = slew_en_q;
    do_latch   = 1'b0;
    case (state_q)
      IDLE: begin
        if (zone_valid && sel_found) do_latch = 1'b1;
      end
      AIM, SETTLE: begin
        if (zone_valid) begin
          if (sel_found) begin
            do_latch = 1'b1;
          end else begin
            state_d   = IDLE;
            tv_d      = 1'b0;
            slew_en_d = 1'b0;
          end
        end else if (state_q == AIM) begin
          if (frame_tick && pan_at && tilt_at) begin
            state_d  = SETTLE;
            settle_d = '0;
          end
        end else if (frame_tick) begin
          if (settle_q == SETTLE_LAST) begin
            state_d    = arm ? FIRE : IDLE;
            fire_cnt_d = '0;
          end else begin
            settle_d = settle_q + 1'b1;
          end
        end
      end
      FIRE: begin
        if (fire_cnt_q == FIRE_LAST) begin
          state_d = IDLE;
          tv_d    = 1'b0;
        end else begin
          fire_cnt_d = fire_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (do_latch) begin
      state_d    = AIM;
      tv_d       = 1'b1;
      idx_d      = sel_idx;
      pan_tgt_d  = axis_width(zone_col(sel_idx));
      tilt_tgt_d = axis_width(zone_row(sel_idx));
      slew_en_d  = 1'b1;
    end
`ifdef AIM_AUTO_HOME_EN
    home_d = home_q;
    if (zone_valid) begin
      home_d = '0;
    end else if (state_q == IDLE && !tv_q && frame_tick) begin
      if (home_q == HW'(HOME_PERIODS - 1)) begin
        home_d     = '0;
        pan_tgt_d  = CENTRE;
        tilt_tgt_d = CENTRE;
        slew_en_d  = 1'b1;
      end else begin
        home_d = home_q + 1'b1;
      end
    end
`endif
    fire_d = (state_d == FIRE);
  end

  always_ff @(posedge fclk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      pan_tgt_q  <= CENTRE;
      tilt_tgt_q <= CENTRE;
      settle_q   <= '0;
      fire_cnt_q <= '0;
      idx_q      <= 4'd4;
      tv_q       <= 1'b0;
      fire_q     <= 1'b0;
      slew_en_q  <= 1'b0;
`ifdef AIM_AUTO_HOME_EN
      home_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pan_tgt_q  <= pan_tgt_d;
      tilt_tgt_q <= tilt_tgt_d;
      settle_q   <= settle_d;
      fire_cnt_q <= fire_cnt_d;
      idx_q      <= idx_d;
      tv_q       <= tv_d;
      fire_q     <= fire_d;
      slew_en_q  <= slew_en_d;
`ifdef AIM_AUTO_HOME_EN
      home_q     <= home_d;
`endif
    end
  end

  servo_slew_pwm #(.W(W), .HOME_WIDTH(CENTRE), .SLEW_STEP(SLEW_W)) u_pan (
    .fclk(fclk), .reset(reset), .frame_tick(slew_tick), .frame_cnt(cnt_q),
    .target_width(pan_tgt_q), .pwm(pan_pwm), .at_target(pan_at)
  );

  servo_slew_pwm #(.W(W), .HOME_WIDTH(CENTRE), .SLEW_STEP(SLEW_W)) u_tilt (
    .fclk(fclk), .reset(reset), .frame_tick(slew_tick), .frame_cnt(cnt_q),
    .target_width(tilt_tgt_q), .pwm(tilt_pwm), .at_target(tilt_at)
  );

  assign fire         = fire_q;
  assign target_valid = tv_q;
  assign target_idx   = idx_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_turret_aim_ctrl.sv
module tb_turret_aim_ctrl;

  localparam int PER = 100;

  logic       clk = 1'b0;
  logic       rst, zv, arm;
  logic [8:0] zone;
  logic       pan_pwm, tilt_pwm, fire, target_valid, busy;
  logic [3:0] target_idx;

  turret_aim_ctrl #(
    .PWM_PERIOD(100), .PULSE_MIN(10), .PULSE_STEP(5), .SLEW_STEP(1),
    .SETTLE_PERIODS(2), .FIRE_CYCLES(4), .HOME_PERIODS(250)
  ) dut (
    .fclk(clk), .reset(rst), .zone_valid(zv), .zone(zone), .arm(arm),
    .pan_pwm(pan_pwm), .tilt_pwm(tilt_pwm), .fire(fire),
    .target_valid(target_valid), .target_idx(target_idx), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Posedges since reset release; mirrors the DUT frame counter position.
  int pcnt;
  always @(posedge clk or posedge rst) begin
    if (rst) pcnt <= 0;
    else     pcnt <= pcnt + 1;
  end

  // Per-frame PWM high-time measurement, sampled on negedges.
  int pa, ta, last_pan, last_tilt;
  int frame_no = 0;
  always @(negedge clk) begin
    if (rst) begin
      pa <= 0;
      ta <= 0;
    end else if (pcnt % PER == 1) begin
      pa <= int'(pan_pwm);
      ta <= int'(tilt_pwm);
    end else begin
      pa <= pa + int'(pan_pwm);
      ta <= ta + int'(tilt_pwm);
      if (pcnt % PER == 0 && pcnt != 0) begin
        last_pan  <= pa + int'(pan_pwm);
        last_tilt <= ta + int'(tilt_pwm);
        frame_no  <= frame_no + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic next_frame(output int p, output int t);
    int  start;
    bit  got;
    start = frame_no;
    got   = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(posedge clk);
      if (frame_no != start) got = 1'b1;
    end
    check("frame_wait", 32'(got), 32'd1);
    p = last_pan;
    t = last_tilt;
  endtask

  task automatic goto_phase(input int ph);
    for (int i = 0; i < 2 * PER; i++) begin
      @(negedge clk);
      if (pcnt % PER == ph) break;
    end
  endtask

  task automatic pulse_zone(input logic [8:0] z);
    zv   = 1'b1;
    zone = z;
    @(negedge clk);
    zv   = 1'b0;
    zone = '0;
  endtask

  task automatic wait_busy_low(output int when, output bit fire_seen);
    when      = -1;
    fire_seen = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (fire) fire_seen = 1'b1;
      if (!busy) begin
        when = pcnt;
        break;
      end
    end
  endtask

  task automatic wait_fire(input bit poke, output int rise, output int width);
    rise  = -1;
    width = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (fire) begin
        rise = pcnt;
        break;
      end
    end
    while (rise >= 0 && fire && width < 20) begin
      width++;
      if (poke && width == 2) begin
        zv   = 1'b1;
        zone = 9'h100;
      end else begin
        zv   = 1'b0;
        zone = '0;
      end
      @(negedge clk);
    end
    zv   = 1'b0;
    zone = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int p, t, base, when, rise, width;
    bit fs;

    rst = 1'b1; zv = 1'b0; zone = '0; arm = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_fire", 32'(fire), 32'd0);
    check("rst_tv", 32'(target_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_idx", 32'(target_idx), 32'd4);
    check("rst_pan_pwm", 32'(pan_pwm), 32'd0);
    check("rst_tilt_pwm", 32'(tilt_pwm), 32'd0);
    rst = 1'b0;
    next_frame(p, t);
    check("rst_pan_w", p, 15);
    check("rst_tilt_w", t, 15);

    // Centre beats edge, already on target, arm low: back to IDLE holding target.
    goto_phase(50);
    base = pcnt;
    pulse_zone(9'b000010010);
    check("c_idx", 32'(target_idx), 32'd4);
    check("c_tv", 32'(target_valid), 32'd1);
    check("c_busy", 32'(busy), 32'd1);
    wait_busy_low(when, fs);
    check("c_idle_time", when, (base / PER + 3) * PER);
    check("c_no_fire", 32'(fs), 32'd0);
    check("c_tv_kept", 32'(target_valid), 32'd1);
    next_frame(p, t);
    check("c_pan_w", p, 15);
    check("c_tilt_w", t, 15);

    // Cells 0 and 8: cell 0 wins, slew 15 -> 10, then armed fire.
    arm = 1'b1;
    goto_phase(50);
    base = pcnt;
    pulse_zone(9'b100000001);
    check("s_idx", 32'(target_idx), 32'd0);
    check("s_tv", 32'(target_valid), 32'd1);
    next_frame(p, t);
    check("s_pan_w0", p, 15);
    for (int i = 1; i <= 5; i++) begin
      next_frame(p, t);
      check("s_pan_w", p, 15 - i);
      check("s_tilt_w", t, 15 - i);
    end
    wait_fire(1'b0, rise, width);
    check("s_fire_rise", rise, (base / PER + 8) * PER);
    check("s_fire_width", width, 4);
    check("s_tv_clear", 32'(target_valid), 32'd0);
    check("s_busy_clear", 32'(busy), 32'd0);

    // Target 2 unarmed: pan slews 10 -> 20, no fire, target kept.
    arm = 1'b0;
    goto_phase(50);
    base = pcnt;
    pulse_zone(9'b000000100);
    check("u_idx", 32'(target_idx), 32'd2);
    wait_busy_low(when, fs);
    check("u_idle_time", when, (base / PER + 13) * PER);
    check("u_no_fire", 32'(fs), 32'd0);
    check("u_tv_kept", 32'(target_valid), 32'd1);
    next_frame(p, t);
    check("u_pan_w", p, 20);
    check("u_tilt_w", t, 10);

    // Armed fire with a zone_valid landing mid-pulse.
    arm = 1'b1;
    goto_phase(50);
    base = pcnt;
    pulse_zone(9'b000000100);
    wait_fire(1'b1, rise, width);
    check("f_fire_rise", rise, (base / PER + 3) * PER);
    check("f_fire_width", width, 4);
    check("f_idx_kept", 32'(target_idx), 32'd2);
    check("f_tv_clear", 32'(target_valid), 32'd0);

    // Reset in the second FIRE cycle.
    goto_phase(50);
    pulse_zone(9'b000000100);
    rise = -1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (fire) begin
        rise = pcnt;
        break;
      end
    end
    check("r_fire_seen", 32'(rise >= 0), 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("r_fire", 32'(fire), 32'd0);
    check("r_tv", 32'(target_valid), 32'd0);
    check("r_busy", 32'(busy), 32'd0);
    check("r_idx", 32'(target_idx), 32'd4);
    check("r_pan_pwm", 32'(pan_pwm), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    next_frame(p, t);
    check("r_pan_w", p, 15);
    check("r_tilt_w", t, 15);

    // Retarget 8 -> 6 mid-slew: pan reverses from 17, tilt carries on to 20.
    arm = 1'b0;
    goto_phase(50);
    pulse_zone(9'b100000000);
    check("m_idx8", 32'(target_idx), 32'd8);
    next_frame(p, t);
    next_frame(p, t);
    check("m_pan_16", p, 16);
    check("m_tilt_16", t, 16);
    goto_phase(50);
    pulse_zone(9'b001000000);
    check("m_idx6", 32'(target_idx), 32'd6);
    check("m_tv", 32'(target_valid), 32'd1);
    next_frame(p, t);
    check("m_pan_17", p, 17);
    check("m_tilt_17", t, 17);
    for (int i = 1; i <= 8; i++) begin
      next_frame(p, t);
      check("m_pan_w", p, (17 - i > 10) ? 17 - i : 10);
      check("m_tilt_w", t, (17 + i < 20) ? 17 + i : 20);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
